// File: rtl/nn_pkg.sv
// Shared constants for the fully-connected inference datapath and the encoding
// of the layer scheduler's state register.
package nn_pkg;

   localparam int DATA_W     = 16;
   localparam int LANES      = 128;
   localparam int ADDR_W     = 11;
   localparam int NUM_LAYERS = 3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_NEXT   = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

endpackage

// File: rtl/fc_bus_mux.sv
// Combinational arbitration of ROM address and MultAdder operands: forwards the
// selected layer's slices while the grant is active, otherwise drives zeros.
module fc_bus_mux #(
   parameter int NUM_LAYERS = nn_pkg::NUM_LAYERS,
   parameter int DATA_W     = nn_pkg::DATA_W,
   parameter int LANES      = nn_pkg::LANES,
   parameter int ADDR_W     = nn_pkg::ADDR_W,
   parameter int SEL_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                               grant,
   input  logic [SEL_W-1:0]                   sel,
   input  logic [NUM_LAYERS*ADDR_W-1:0]       layer_addr,
   input  logic [NUM_LAYERS*LANES*DATA_W-1:0] layer_opr1,
   input  logic [NUM_LAYERS*LANES*DATA_W-1:0] layer_opr2,
   output logic [ADDR_W-1:0]                  rom_addr,
   output logic [LANES*DATA_W-1:0]            mult_opr1,
   output logic [LANES*DATA_W-1:0]            mult_opr2
);

   localparam int OPR_W = LANES * DATA_W;

   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      rom_addr  = '0;
      mult_opr1 = '0;
      mult_opr2 = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (grant && sel == SEL_W'(i)) begin
            rom_addr  = layer_addr[i*ADDR_W +: ADDR_W];
            mult_opr1 = layer_opr1[i*OPR_W +: OPR_W];
            mult_opr2 = layer_opr2[i*OPR_W +: OPR_W];
         end
      end
   end

endmodule

// File: rtl/fc_layer_scheduler.sv
// Sequences the fully-connected layers one at a time over the shared MultAdder
// and weight ROM, with a per-layer reset pulse and a RUN-phase watchdog.
module fc_layer_scheduler #(
   parameter int NUM_LAYERS  = nn_pkg::NUM_LAYERS,
   parameter int DATA_W      = nn_pkg::DATA_W,
   parameter int LANES       = nn_pkg::LANES,
   parameter int ADDR_W      = nn_pkg::ADDR_W,
   parameter int TIMEOUT_CYC = 4096,
   parameter int SEL_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                               clk,
   input  logic                               iRst,
   input  logic                               iStart,
   output logic                               oBusy,
   output logic                               oDone,
   output logic                               oTimeout,
   output logic [SEL_W-1:0]                   oLayerSel,
   output logic [NUM_LAYERS-1:0]              oLayerEna,
   output logic [NUM_LAYERS-1:0]              oLayerRst_n,
   input  logic [NUM_LAYERS-1:0]              iLayerDone,
   input  logic [NUM_LAYERS*ADDR_W-1:0]       iLayerAddr,
   input  logic [NUM_LAYERS*LANES*DATA_W-1:0] iLayerOpr1,
   input  logic [NUM_LAYERS*LANES*DATA_W-1:0] iLayerOpr2,
   output logic [ADDR_W-1:0]                  oAddrToRom,
   output logic [LANES*DATA_W-1:0]            oOpr1ToMultAdder,
   output logic [LANES*DATA_W-1:0]            oOpr2ToMultAdder
);

   import nn_pkg::ST_IDLE, nn_pkg::ST_CLEAR, nn_pkg::ST_RUN,
          nn_pkg::ST_NEXT, nn_pkg::ST_FINISH, nn_pkg::ST_ERR;

   localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [2:0]       state;
   logic [SEL_W-1:0] sel;
   logic [WD_W-1:0]  wd;
   logic             cur_done;
   logic             last_layer;
   logic             grant;

   assign cur_done   = iLayerDone[sel];
   assign last_layer = (sel == SEL_W'(NUM_LAYERS - 1));
   assign grant      = (state == ST_CLEAR) || (state == ST_RUN);

   // wd doubles as the 2-cycle CLEAR timer and the RUN watchdog; it is zeroed
   // on every state change so each phase counts from 0.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (iRst) begin
         state <= ST_IDLE;
         sel   <= '0;
         wd    <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_FINISH, ST_ERR: begin
               if (iStart) begin
                  state <= ST_CLEAR;
                  sel   <= '0;
                  wd    <= '0;
               end
            end
            ST_CLEAR: begin
               if (wd == WD_W'(1)) begin
                  state <= ST_RUN;
                  wd    <= '0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_RUN: begin
               // Done is tested first so it beats a simultaneous watchdog expiry.
               if (cur_done) begin
                  state <= last_layer ? ST_FINISH : ST_NEXT;
                  wd    <= '0;
               end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                  state <= ST_ERR;
                  wd    <= '0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_NEXT: begin
               state <= ST_CLEAR;
               sel   <= sel + 1'b1;
               wd    <= '0;
            end
            default: begin
               state <= ST_IDLE;
               sel   <= '0;
               wd    <= '0;
            end
         endcase
      end
   end

   assign oBusy     = grant || (state == ST_NEXT);
   assign oDone     = (state == ST_FINISH);
   assign oTimeout  = (state == ST_ERR);
   assign oLayerSel = sel;

   always_comb begin
      oLayerEna   = '0;
      oLayerRst_n = '1;
      if (grant) begin
         oLayerEna[sel] = 1'b1;
         if (state == ST_CLEAR) oLayerRst_n[sel] = 1'b0;
      end
   end

   fc_bus_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .DATA_W     (DATA_W),
      .LANES      (LANES),
      .ADDR_W     (ADDR_W),
      .SEL_W      (SEL_W)
   ) u_bus_mux (
      .grant      (grant),
      .sel        (sel),
      .layer_addr (iLayerAddr),
      .layer_opr1 (iLayerOpr1),
      .layer_opr2 (iLayerOpr2),
      .rom_addr   (oAddrToRom),
      .mult_opr1  (oOpr1ToMultAdder),
      .mult_opr2  (oOpr2ToMultAdder)
   );

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Self-checking bench: a phase trace derived from the sequencing rules predicts
// every output cycle by cycle, for a default instance and a 16-cycle watchdog one.
module tb_fc_layer_scheduler;

   localparam int N  = nn_pkg::NUM_LAYERS;
   localparam int AW = nn_pkg::ADDR_W;
   localparam int OW = nn_pkg::LANES * nn_pkg::DATA_W;

   typedef enum {P_IDLE, P_CLEAR, P_RUN, P_NEXT, P_FINISH, P_ERR} phase_t;
   typedef struct {
      phase_t ph;
      int     sel;
      bit     done;
   } step_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [N-1:0]    layer_done;
   logic [N*AW-1:0] layer_addr;
   logic [N*OW-1:0] layer_opr1;
   logic [N*OW-1:0] layer_opr2;

   logic            a_busy, a_done, a_tmo, b_busy, b_done, b_tmo;
   logic [1:0]      a_sel, b_sel;
   logic [N-1:0]    a_ena, a_rstn, b_ena, b_rstn;
   logic [AW-1:0]   a_addr, b_addr;
   logic [OW-1:0]   a_o1, a_o2, b_o1, b_o2;

   logic            use_b;
   logic            obs_busy, obs_done, obs_tmo;
   logic [1:0]      obs_sel;
   logic [N-1:0]    obs_ena, obs_rstn;
   logic [AW-1:0]   obs_addr;
   logic [OW-1:0]   obs_o1, obs_o2;

   int              checks = 0;
   int              errors = 0;
   step_t           trace[$];

   always #5 clk = ~clk;

   fc_layer_scheduler dut_a (
      .clk(clk), .iRst(rst), .iStart(start),
      .oBusy(a_busy), .oDone(a_done), .oTimeout(a_tmo), .oLayerSel(a_sel),
      .oLayerEna(a_ena), .oLayerRst_n(a_rstn), .iLayerDone(layer_done),
      .iLayerAddr(layer_addr), .iLayerOpr1(layer_opr1), .iLayerOpr2(layer_opr2),
      .oAddrToRom(a_addr), .oOpr1ToMultAdder(a_o1), .oOpr2ToMultAdder(a_o2)
   );

   fc_layer_scheduler #(.TIMEOUT_CYC(16)) dut_b (
      .clk(clk), .iRst(rst), .iStart(start),
      .oBusy(b_busy), .oDone(b_done), .oTimeout(b_tmo), .oLayerSel(b_sel),
      .oLayerEna(b_ena), .oLayerRst_n(b_rstn), .iLayerDone(layer_done),
      .iLayerAddr(layer_addr), .iLayerOpr1(layer_opr1), .iLayerOpr2(layer_opr2),
      .oAddrToRom(b_addr), .oOpr1ToMultAdder(b_o1), .oOpr2ToMultAdder(b_o2)
   );

   always_comb begin
      obs_busy = use_b ? b_busy : a_busy;
      obs_done = use_b ? b_done : a_done;
      obs_tmo  = use_b ? b_tmo  : a_tmo;
      obs_sel  = use_b ? b_sel  : a_sel;
      obs_ena  = use_b ? b_ena  : a_ena;
      obs_rstn = use_b ? b_rstn : a_rstn;
      obs_addr = use_b ? b_addr : a_addr;
      obs_o1   = use_b ? b_o1   : a_o1;
      obs_o2   = use_b ? b_o2   : a_o2;
   end

   // Expected phase sequence from the scheduling rules: two CLEAR cycles, RUN until
   // the layer's done latency or the watchdog limit, then NEXT / FINISH / ERR.
   task automatic build_trace(input int lat0, input int lat1, input int lat2, input int tmo);
      int     lat[3];
      phase_t endp;
      int     ends;
      bit     timed;
      lat  = '{lat0, lat1, lat2};
      endp = P_FINISH;
      ends = N - 1;
      trace.delete();
      for (int l = 0; l < N; l++) begin
         timed = 0;
         trace.push_back('{P_CLEAR, l, 1'b0});
         trace.push_back('{P_CLEAR, l, 1'b0});
         for (int r = 0; r < tmo; r++) begin
            if (r == lat[l]) begin
               trace.push_back('{P_RUN, l, 1'b1});
               break;
            end
            trace.push_back('{P_RUN, l, 1'b0});
            if (r == tmo - 1) begin
               timed = 1;
               break;
            end
         end
         if (timed) begin
            endp = P_ERR;
            ends = l;
            break;
         end
         if (l < N - 1) trace.push_back('{P_NEXT, l, 1'b0});
      end
      repeat (3) trace.push_back('{endp, ends, 1'b0});
   endtask

   task automatic randomize_data();
      for (int l = 0; l < N; l++) layer_addr[l*AW +: AW] = AW'($urandom());
      for (int k = 0; k < N*OW/32; k++) begin
         layer_opr1[k*32 +: 32] = $urandom();
         layer_opr2[k*32 +: 32] = $urandom();
      end
   endtask

   task automatic check_step(input step_t s, input int c, input string name);
      bit            grant;
      logic [N-1:0]  e_ena, e_rstn;
      logic          e_busy, e_done, e_tmo;
      logic [AW-1:0] e_addr;
      logic [OW-1:0] e_o1, e_o2;
      grant  = (s.ph == P_CLEAR) || (s.ph == P_RUN);
      e_ena  = '0;
      e_rstn = '1;
      if (grant) e_ena[s.sel] = 1'b1;
      if (s.ph == P_CLEAR) e_rstn[s.sel] = 1'b0;
      e_busy = grant || (s.ph == P_NEXT);
      e_done = (s.ph == P_FINISH);
      e_tmo  = (s.ph == P_ERR);
      e_addr = grant ? layer_addr[s.sel*AW +: AW] : '0;
      e_o1   = grant ? layer_opr1[s.sel*OW +: OW] : '0;
      e_o2   = grant ? layer_opr2[s.sel*OW +: OW] : '0;

      checks++;
      if ({obs_busy, obs_done, obs_tmo, obs_ena, obs_rstn} !== {e_busy, e_done, e_tmo, e_ena, e_rstn}) begin
         errors++;
         $display("FAIL %s ctrl cyc %0d (%s): busy/done/tmo/ena/rst_n actual=%b required=%b",
                  name, c, s.ph.name(), {obs_busy, obs_done, obs_tmo, obs_ena, obs_rstn},
                  {e_busy, e_done, e_tmo, e_ena, e_rstn});
      end
      if (grant || s.ph == P_IDLE) begin
         checks++;
         if (obs_sel !== 2'(s.sel)) begin
            errors++;
            $display("FAIL %s sel cyc %0d (%s): actual=%0d required=%0d", name, c, s.ph.name(), obs_sel, s.sel);
         end
      end
      checks++;
      if (obs_addr !== e_addr) begin
         errors++;
         $display("FAIL %s rom_addr cyc %0d (%s): actual=%h required=%h", name, c, s.ph.name(), obs_addr, e_addr);
      end
      checks++;
      if (obs_o1 !== e_o1) begin
         errors++;
         $display("FAIL %s opr1 cyc %0d (%s): actual[31:0]=%h required[31:0]=%h", name, c, s.ph.name(), obs_o1[31:0], e_o1[31:0]);
      end
      checks++;
      if (obs_o2 !== e_o2) begin
         errors++;
         $display("FAIL %s opr2 cyc %0d (%s): actual[31:0]=%h required[31:0]=%h", name, c, s.ph.name(), obs_o2[31:0], e_o2[31:0]);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      start      = 1'b0;
      layer_done = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge. Pulses start, then walks the trace; abort_at >= 0 applies
   // reset (together with start) at that trace cycle instead of continuing.
   task automatic run_trace(input string name, input int abort_at);
      start      = 1'b1;
      layer_done = '0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < trace.size(); c++) begin
         if (c == abort_at) begin
            rst        = 1'b1;
            start      = 1'b1;
            layer_done = '1;
            @(posedge clk);
            @(negedge clk);
            rst        = 1'b0;
            start      = 1'b0;
            layer_done = '0;
            check_step('{P_IDLE, 0, 1'b0}, c, {name, "_abort"});
            return;
         end
         check_step(trace[c], c, name);
         if (trace[c].ph == P_RUN || trace[c].ph == P_CLEAR) begin
            layer_done = N'($urandom());
            layer_done[trace[c].sel] = trace[c].done;
         end else begin
            layer_done = '0;
         end
         start = (trace[c].ph inside {P_CLEAR, P_RUN, P_NEXT}) && ($urandom_range(0, 3) == 0);
         @(posedge clk);
         @(negedge clk);
      end
      layer_done = '0;
      start      = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      use_b = 1'b0;
      check_step('{P_IDLE, 0, 1'b0}, 0, "reset_a");
      use_b = 1'b1;
      check_step('{P_IDLE, 0, 1'b0}, 0, "reset_b");
      @(posedge clk);
      @(negedge clk);
      check_step('{P_IDLE, 0, 1'b0}, 1, "reset_b_hold");
   endtask

   task automatic test_normal();
      use_b = 1'b0;
      do_reset();
      randomize_data();
      layer_addr[1*AW +: AW] = 11'h482;
      build_trace(40, 60, 30, 4096);
      run_trace("normal", -1);
   endtask

   task automatic test_back_to_back();
      use_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         randomize_data();
         build_trace($urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 80), 4096);
         run_trace($sformatf("b2b%0d", i), -1);
      end
   endtask

   task automatic test_watchdog();
      use_b = 1'b1;
      do_reset();
      randomize_data();
      build_trace(1000, 0, 0, 16);
      run_trace("watchdog", -1);
      randomize_data();
      build_trace($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14), 16);
      run_trace("wd_restart", -1);
   endtask

   task automatic test_race();
      use_b = 1'b1;
      do_reset();
      randomize_data();
      build_trace(15, 15, 15, 16);
      run_trace("race_all", -1);
      build_trace(3, 15, 1000, 16);
      run_trace("race_then_tmo", -1);
   endtask

   task automatic test_reset_mid();
      use_b = 1'b0;
      do_reset();
      randomize_data();
      build_trace(40, 60, 30, 4096);
      // Index 51: layer 0 takes CLEAR x2 + 41 RUN + NEXT, layer 1 CLEAR x2, then RUN r=5.
      run_trace("reset_mid", 51);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check_step('{P_IDLE, 0, 1'b0}, 0, "reset_mid_idle");
      end
      build_trace(5, 7, 9, 4096);
      run_trace("after_reset", -1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "time limit");
   end

   initial begin
      use_b      = 1'b0;
      rst        = 1'b1;
      start      = 1'b0;
      layer_done = '0;
      layer_addr = '0;
      layer_opr1 = '0;
      layer_opr2 = '0;
      @(negedge clk);
      test_reset();
      test_normal();
      test_back_to_back();
      test_watchdog();
      test_race();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fc_layer_scheduler.md
FC_LAYER_SCHEDULER -- requirements
Module: fc_layer_scheduler

Interface
REQ-001 Parameter NUM_LAYERS, default 3: number of fully-connected layer units sharing the MultAdder and weight ROM.
REQ-002 Parameter DATA_W, default 16: element width in bits.
REQ-003 Parameter LANES, default 128: MultAdder lanes; operand bus is LANES*DATA_W = 2048 bits.
REQ-004 Parameter ADDR_W, default 11: weight ROM address width.
REQ-005 Parameter TIMEOUT_CYC, default 4096: watchdog limit in cycles per layer.
REQ-006 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 Port iRst, input, 1: synchronous, active-high reset.
REQ-008 Port iStart, input, 1: start pulse for the whole inference.
REQ-009 Port oBusy, output, 1: high while any layer is being sequenced.
REQ-010 Port oDone, output, 1: all layers completed; level-held.
REQ-011 Port oTimeout, output, 1: watchdog expired; level-held.
REQ-012 Port oLayerSel, output, 2: index of the granted layer.
REQ-013 Port oLayerEna, output, NUM_LAYERS: one-hot ena to the layer units.
REQ-014 Port oLayerRst_n, output, NUM_LAYERS: active-low per-layer reset (the layers' iRst_n).
REQ-015 Port iLayerDone, input, NUM_LAYERS: done flags from the layer units.
REQ-016 Port iLayerAddr, input, NUM_LAYERS*ADDR_W: ROM address request per layer.
REQ-017 Ports iLayerOpr1 and iLayerOpr2, input, NUM_LAYERS*LANES*DATA_W: MultAdder operands per layer.
REQ-018 Port oAddrToRom, output, ADDR_W: arbitrated ROM address.
REQ-019 Ports oOpr1ToMultAdder and oOpr2ToMultAdder, output, LANES*DATA_W: arbitrated operands.

Function
REQ-020 FSM states: IDLE, CLEAR, RUN, NEXT, FINISH, ERR.
REQ-021 IDLE: iStart=1 -> CLEAR with oLayerSel=0, oDone=0, oTimeout=0, oBusy=1.
REQ-022 CLEAR: lasts exactly 2 cycles; oLayerEna[sel]=1 and oLayerRst_n[sel]=0; then RUN.
REQ-023 RUN: oLayerEna[sel]=1, oLayerRst_n[sel]=1; watchdog counter starts from 0 on entry and increments each cycle.
REQ-024 RUN with iLayerDone[sel]=1: go to NEXT if sel<NUM_LAYERS-1, otherwise go to FINISH.
REQ-025 NEXT: one cycle with all ena=0; sel increments; then CLEAR.
REQ-026 FINISH: all ena=0, oDone=1, oBusy=0; iStart restarts at REQ-021.
REQ-027 RUN with the watchdog reaching TIMEOUT_CYC-1 and no done: go to ERR; all ena=0, oTimeout=1, oBusy=0; iStart restarts at REQ-021.
REQ-028 Done and watchdog expiry in the same cycle: done wins.
REQ-029 iLayerDone of a non-selected layer is ignored.
REQ-030 iStart in CLEAR, RUN or NEXT is ignored.
REQ-031 Arbitration mux is combinational with zero latency: in CLEAR and RUN, oAddrToRom, oOpr1ToMultAdder and oOpr2ToMultAdder equal the selected layer's slices; in every other state they are 0, never z.
REQ-032 Non-selected layers always see ena=0 and rst_n=1.
REQ-033 One-hot rule: at most one oLayerEna bit high in any cycle.

Reset
REQ-034 iRst=1 at a clock edge: state IDLE, oBusy=0, oDone=0, oTimeout=0, oLayerSel=0, oLayerEna=0, oLayerRst_n all 1, mux outputs 0, watchdog 0.
REQ-035 Reset mid-operation aborts at once, with no NEXT/FINISH cycle; iRst overrides iStart in the same cycle.

Structure
REQ-036 Shared package nn_pkg holds DATA_W, LANES, ADDR_W, NUM_LAYERS and the scheduler state encoding.
REQ-037 The mux lives in sub-module fc_bus_mux (purely combinational); FSM and watchdog stay in the top module.

Verification
REQ-038 Normal run: iStart pulse; layers assert done 40, 60 and 30 cycles after their RUN entry -> sel sequence 0,1,2; each CLEAR lasts 2 cycles; each NEXT lasts 1 cycle; oDone=1 in the cycle after layer 2's done is sampled.
REQ-039 Mux check: layer1 addr=11'h482 with distinct operand patterns per layer -> during layer 1 RUN the outputs equal layer1 values; in NEXT/IDLE they are 0.
REQ-040 Watchdog: TIMEOUT_CYC=16; layer0 never asserts done -> ERR after 16 RUN cycles, oTimeout=1, ena=0; a following iStart restarts cleanly.
REQ-041 Race: iLayerDone[sel] asserted in the watchdog-expiry cycle -> NEXT, oTimeout stays 0.
REQ-042 Reset mid-RUN of layer 1 -> next cycle all outputs at reset values; iStart while busy and spurious iLayerDone[2] during layer 0 have no effect.
